// File: rtl/video_timing_monitor_if.sv
// Video timing bundle: syncs and de from the source,
// measured geometry and lock status back from the monitor.
interface video_timing_monitor_if #(
  parameter int CNT_W = 12
);
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [CNT_W-1:0] h_total;
  logic [CNT_W-1:0] h_active;
  logic [CNT_W-1:0] v_total;
  logic [CNT_W-1:0] v_active;
  logic             meas_valid;
  logic             locked;
  logic             frame_err;

  modport master (
    output hsync, vsync, de,
    input  h_total, h_active,
    input  v_total, v_active,
    input  meas_valid, locked, frame_err
  );

  modport slave (
    input  hsync, vsync, de,
    output h_total, h_active,
    output v_total, v_active,
    output meas_valid, locked, frame_err
  );
endinterface

// File: rtl/video_timing_monitor.sv
// Pixel-clock video timing monitor: measures line/frame geometry,
// checks frame consistency and flags lock. Ports: clk, rst_n, mon.
module video_timing_monitor #(
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 2,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  video_timing_monitor_if.slave mon
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] TRACK   = 2'd2;

  function automatic logic [CNT_W-1:0] inc_sat(
    input logic [CNT_W-1:0] v
  );
    return (v == CMAX) ? v : v + ONE;
  endfunction

  // {de, vs, hs}, syncs normalised to active-high
  logic [2:0] s1_q;
  logic [1:0] s2_q;
  logic       hs_e_q;
  logic       vs_e_q;
  logic       de_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      hs_e_q <= 1'b0;
      vs_e_q <= 1'b0;
      de_q   <= 1'b0;
    end else begin
      s1_q   <= {mon.de,
                 mon.vsync ~^ VS_POL,
                 mon.hsync ~^ HS_POL};
      s2_q   <= s1_q[1:0];
      hs_e_q <= s1_q[0] & ~s2_q[0];
      vs_e_q <= s1_q[1] & ~s2_q[1];
      de_q   <= s1_q[2];
    end
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] rl_q, rl_d;
  logic [CNT_W-1:0] ra_q, ra_d;
  logic             rl_v_q, rl_v_d;
  logic             ra_v_q, ra_v_d;
  logic             bad_q, bad_d;
  logic             psat_q, psat_d;
  logic [3:0]       match_q, match_d;
  logic             lock_q, lock_d;
  logic [CNT_W-1:0] ht_q, ht_d;
  logic [CNT_W-1:0] ha_q, ha_d;
  logic [CNT_W-1:0] vt_q, vt_d;
  logic [CNT_W-1:0] va_q, va_d;
  logic             mv_q, mv_d;
  logic             fe_q, fe_d;

  // Frame state including the line closed this cycle;
  // on a coincident vsync that line still belongs to
  // the frame being closed.
  logic [CNT_W-1:0] rl_e, ra_e, act_e, line_e;
  logic             rl_v_e, ra_v_e, bad_e, psat_e;

  always_comb begin
    rl_e   = rl_q;
    rl_v_e = rl_v_q;
    ra_e   = ra_q;
    ra_v_e = ra_v_q;
    bad_e  = bad_q;
    act_e  = act_q;
    line_e = line_q;
    psat_e = psat_q | (pix_q == CMAX);
    if (hs_e_q) begin
      line_e = inc_sat(line_q);
      if (!rl_v_q) begin
        rl_e   = pix_q;
        rl_v_e = 1'b1;
      end else if (pix_q != rl_q) begin
        bad_e = 1'b1;
      end
      if (dcnt_q != '0) begin
        act_e = inc_sat(act_q);
        if (!ra_v_q) begin
          ra_e   = dcnt_q;
          ra_v_e = 1'b1;
        end else if (dcnt_q != ra_q) begin
          bad_e = 1'b1;
        end
      end
    end
  end

  logic srch, f_bad, f_ok, same;

  always_comb begin
    srch  = (state_q == SEARCH);
    f_bad = ~srch &
            (bad_e | psat_e |
             (line_q == CMAX) |
             (line_q == '0));
    f_ok  = ~srch & ~f_bad;
    same  = (rl_e == ht_q) &&
            (ra_e == ha_q) &&
            (line_q == vt_q) &&
            (act_e == va_q);
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    lock_d  = lock_q;
    ht_d    = ht_q;
    ha_d    = ha_q;
    vt_d    = vt_q;
    va_d    = va_q;
    mv_d    = 1'b0;
    fe_d    = 1'b0;
    pix_d   = hs_e_q ? ONE : inc_sat(pix_q);
    dcnt_d  = hs_e_q ? '0 :
              de_q   ? inc_sat(dcnt_q) : dcnt_q;
    line_d  = line_e;
    act_d   = act_e;
    rl_d    = rl_e;
    rl_v_d  = rl_v_e;
    ra_d    = ra_e;
    ra_v_d  = ra_v_e;
    bad_d   = bad_e;
    psat_d  = psat_e;
    if (vs_e_q) begin
      line_d = hs_e_q ? ONE : '0;
      act_d  = '0;
      rl_d   = '0;
      rl_v_d = 1'b0;
      ra_d   = '0;
      ra_v_d = 1'b0;
      bad_d  = 1'b0;
      psat_d = 1'b0;
      unique case (1'b1)
        srch: begin
          state_d = MEASURE;
        end
        f_bad: begin
          fe_d    = 1'b1;
          match_d = '0;
          lock_d  = 1'b0;
          state_d = MEASURE;
        end
        f_ok: begin
          mv_d = 1'b1;
          ht_d = rl_e;
          ha_d = ra_e;
          vt_d = line_q;
          va_d = act_e;
          if (!same)
            match_d = 4'd1;
          else if (match_q != LOCK_N)
            match_d = match_q + 4'd1;
          lock_d  = (match_d == LOCK_N);
          state_d = TRACK;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      pix_q   <= '0;
      dcnt_q  <= '0;
      line_q  <= '0;
      act_q   <= '0;
      rl_q    <= '0;
      ra_q    <= '0;
      rl_v_q  <= 1'b0;
      ra_v_q  <= 1'b0;
      bad_q   <= 1'b0;
      psat_q  <= 1'b0;
      match_q <= '0;
      lock_q  <= 1'b0;
      ht_q    <= '0;
      ha_q    <= '0;
      vt_q    <= '0;
      va_q    <= '0;
      mv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      dcnt_q  <= dcnt_d;
      line_q  <= line_d;
      act_q   <= act_d;
      rl_q    <= rl_d;
      ra_q    <= ra_d;
      rl_v_q  <= rl_v_d;
      ra_v_q  <= ra_v_d;
      bad_q   <= bad_d;
      psat_q  <= psat_d;
      match_q <= match_d;
      lock_q  <= lock_d;
      ht_q    <= ht_d;
      ha_q    <= ha_d;
      vt_q    <= vt_d;
      va_q    <= va_d;
      mv_q    <= mv_d;
      fe_q    <= fe_d;
    end
  end

  assign mon.h_total    = ht_q;
  assign mon.h_active   = ha_q;
  assign mon.v_total    = vt_q;
  assign mon.v_active   = va_q;
  assign mon.meas_valid = mv_q;
  assign mon.locked     = lock_q;
  assign mon.frame_err  = fe_q;
endmodule
